// File: rtl/operand_scoreboard_if.sv
// Decode-to-operand-fetch bundle: per-slot read/write descriptors in, per-slot grants and busy map out.
interface operand_scoreboard_if #(
  parameter int unsigned ISSUE = 2,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned LW    = 3
);
  logic                    flush;
  logic                    hold;
  logic [ISSUE-1:0]        issue_valid;
  logic [2*ISSUE-1:0]      rd_en;
  logic [2*ISSUE*AW-1:0]   rd_addr;
  logic [ISSUE-1:0]        wr_en;
  logic [ISSUE*AW-1:0]     wr_addr;
  logic [ISSUE*LW-1:0]     wr_lat;
  logic [ISSUE-1:0]        issue_grant;
  logic                    stall;
  logic [NREG-1:0]         busy_vec;

  modport master (
    output flush, hold, issue_valid, rd_en, rd_addr, wr_en, wr_addr, wr_lat,
    input  issue_grant, stall, busy_vec
  );

  modport slave (
    input  flush, hold, issue_valid, rd_en, rd_addr, wr_en, wr_addr, wr_lat,
    output issue_grant, stall, busy_vec
  );
endinterface

// File: rtl/operand_scoreboard.sv
// Per-register latency scoreboard: grants in-order issue per slot, blocking on pending
// producers (RAW/WAW) and on hazards between slots of the same bundle.
module operand_scoreboard #(
  parameter int unsigned ISSUE = 2,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned LW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_scoreboard_if.slave  sb
);

  logic [LW-1:0]    cnt_q [NREG];
  logic [LW-1:0]    cnt_d [NREG];
  logic [ISSUE-1:0] raw_sb;
  logic [ISSUE-1:0] waw_sb;
  logic [ISSUE-1:0] raw_in;
  logic [ISSUE-1:0] waw_in;
  logic [ISSUE-1:0] grant;

  // Register 0 and out-of-range addresses read as never pending.
  function automatic logic [LW-1:0] cnt_at(input logic [AW-1:0] a);
    if (a == '0 || 32'(a) >= NREG) return '0;
    return cnt_q[a];
  endfunction

  always_comb begin
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [AW-1:0] wj;
    logic [LW-1:0] lat;
    logic          wj_live;
    raw_sb  = '0;
    waw_sb  = '0;
    raw_in  = '0;
    waw_in  = '0;
    ra      = '0;
    wa      = '0;
    wj      = '0;
    lat     = '0;
    wj_live = 1'b0;
    for (int unsigned i = 0; i < ISSUE; i++) begin
      wa  = sb.wr_addr[i*AW +: AW];
      lat = sb.wr_lat[i*LW +: LW];
      if (sb.wr_en[i] && cnt_at(wa) > lat) waw_sb[i] = 1'b1;
      for (int unsigned p = 0; p < 2; p++) begin
        ra = sb.rd_addr[(2*i+p)*AW +: AW];
        if (sb.rd_en[2*i+p] && cnt_at(ra) != '0) raw_sb[i] = 1'b1;
      end
      for (int unsigned j = 0; j < i; j++) begin
        wj      = sb.wr_addr[j*AW +: AW];
        wj_live = sb.issue_valid[j] && sb.wr_en[j] && (wj != '0);
        if (wj_live && sb.wr_en[i] && wa == wj) waw_in[i] = 1'b1;
        for (int unsigned p = 0; p < 2; p++) begin
          ra = sb.rd_addr[(2*i+p)*AW +: AW];
          if (wj_live && sb.rd_en[2*i+p] && ra == wj) raw_in[i] = 1'b1;
        end
      end
    end
  end

  // hold only gates slot 0 explicitly; younger slots inherit it through the grant chain.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < ISSUE; i++) begin
      if (i == 0)
        grant[i] = sb.issue_valid[0] & ~sb.hold & ~raw_sb[0] & ~waw_sb[0];
      else
        grant[i] = grant[i-1] & sb.issue_valid[i] &
                   ~raw_sb[i] & ~waw_sb[i] & ~raw_in[i] & ~waw_in[i];
    end
  end

  always_comb begin
    logic [AW-1:0] wa;
    wa = '0;
    for (int unsigned r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
    if (sb.flush) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_d[r] = '0;
    end else if (!sb.hold) begin
      for (int unsigned r = 0; r < NREG; r++)
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
      // New producers override the decrement; at most one granted writer per register.
      for (int unsigned i = 0; i < ISSUE; i++) begin
        wa = sb.wr_addr[i*AW +: AW];
        if (grant[i] && sb.wr_en[i] && wa != '0 && 32'(wa) < NREG)
          cnt_d[wa] = sb.wr_lat[i*LW +: LW];
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    sb.busy_vec = '0;
    for (int unsigned r = 1; r < NREG; r++) sb.busy_vec[r] = (cnt_q[r] != '0);
  end

  assign sb.issue_grant = grant;
  assign sb.stall       = sb.issue_valid[0] & ~grant[0];

endmodule

// File: doc/operand_scoreboard.md
Name: operand_scoreboard

Overview:
- Parametrised successor to the fixed two-slot load-use checker in operand fetch.
- Tracks every in-flight register write with a per-register latency countdown, so producers of any latency (loads, mul/div, CP0 reads) stall consumers only until their result reaches the forwarding network.
- Grants issue per slot, splits a bundle on intra-bundle RAW/WAW hazards, and flushes on exception or branch.
- Sits between decode and the operand mux. The forwarding mux itself stays outside this block.

Parameters:
ISSUE, 2, issue slots per bundle (1..4)
NREG, 32, architectural registers; register 0 is never tracked
AW, 5, register address width, equal to clog2(NREG)
LW, 3, latency counter width; maximum producer latency is 2^LW-1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  clears all pending state at the clock edge
hold  in  1  downstream stall; freezes counters and blocks issue
issue_valid  in  ISSUE  slot i holds a valid instruction (slot 0 is oldest)
rd_en  in  2*ISSUE  read enables; slot i owns bits 2i and 2i+1
rd_addr  in  2*ISSUE*AW  read addresses, packed in the same order as rd_en
wr_en  in  ISSUE  slot writes a register
wr_addr  in  ISSUE*AW  destination per slot
wr_lat  in  ISSUE*LW  cycles from issue until the result is forwardable; 0 means forwardable at issue
issue_grant  out  ISSUE  slot i may issue this cycle
stall  out  1  issue_valid[0] & ~issue_grant[0]
busy_vec  out  NREG  bit r set when cnt[r] != 0

Behaviour:
- State: cnt[r], LW bits per register r in 1..NREG-1. Register 0 is hard-wired to 0.
- Reset (rst=1 at the edge): all cnt=0. Outputs are combinational from state, so after reset issue_grant=all ones where issue_valid is set, stall=0, busy_vec=0.
- flush (rst=0): all cnt=0 at the edge. flush overrides same-cycle issue and decrement.
- Per-slot hazards, all combinational in the same cycle:
  - RAW_sb: an enabled read of r with cnt[r] != 0.
  - WAW_sb: wr_en and cnt[wr_addr] > wr_lat. An older, longer-latency write would land later than this one.
  - RAW_in: an enabled read matches wr_addr of an earlier valid, wr_en slot j<i in the bundle.
  - WAW_in: wr_addr matches an earlier valid, wr_en slot's address.
  - Address 0 never creates a hazard.
- Grant rules:
  - issue_grant[0] = issue_valid[0] & ~hold & ~RAW_sb0 & ~WAW_sb0.
  - issue_grant[i] = issue_grant[i-1] & issue_valid[i] & no hazards of any kind for slot i. Grants are in order, so a younger slot never issues past a blocked older one.
- Sequential update when not flush/rst:
  - If hold=1: cnt unchanged.
  - Else each nonzero cnt decrements by 1 (saturates at 0).
  - Then, for every granted slot with wr_en and wr_addr != 0, cnt[wr_addr] = wr_lat. The new value overrides the decrement.
  - WAW_in guarantees at most one granted writer per register.
- Latency meaning: a consumer of r issues in the first cycle where cnt[r] == 0. A producer with wr_lat=L issued at cycle t therefore allows a consumer at cycle t+L+1.
- wr_lat=0 leaves cnt=0 after issue, so the consumer in the next cycle is not stalled (plain ALU forwarding).
- hold and flush in the same cycle: flush wins.
- rst mid-operation: same as flush. Pending producers are forgotten.

Test Plan:
1. Reset, then issue slot0 writing r5 with wr_lat=2 and slot1 idle. Next cycles present slot0 reading r5 → stall=1 for 2 cycles, then stall=0 and issue_grant[0]=1 in the 3rd cycle; busy_vec[5] is 1 for 2 cycles.
2. Bundle: slot0 writes r3 (lat 0), slot1 reads r3 → issue_grant=2'b01 and cnt[3]=0. Next cycle slot1's instruction is re-presented as slot0 → granted.
3. Slot0 writes r0 with lat 7, then a read of r0 → never stalls; busy_vec[0]=0.
4. r7 pending with cnt=4, hold=1 for 3 cycles → cnt stays 4 and issue_grant=0. After hold drops, cnt counts 3,2,1,0 before a reader of r7 is granted.
5. Pending r9 cnt=3; new write to r9 with lat 1 → WAW_sb stall. With lat 3 → granted, cnt[9]=3.
6. Pending r2 and r4 (cnt 5, 6); assert flush together with a valid slot0 write to r8 lat 2 → all cnt=0 next cycle, busy_vec=0, and r8 is not tracked.
